keypad_col_reader: RTL and testbench

- Parametrised, debounced successor to the keypad column pin readers.
- Synchronises N_COLS column pins through a configurable flip-flop chain and decodes them to one-hot, active-high.
- Debounces both press and release with a counter-based FSM.
- Emits a stable one-hot sense vector, binary column index, single-cycle press/release strobes and a multi-key error flag to the scan FSM.

---
 rtl/keypad_pkg.sv | 23 ++
 rtl/pin_sync.sv | 27 ++
 rtl/keypad_col_reader.sv | 138 +++++++++++++
 tb/tb_keypad_col_reader.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and one-hot helpers for the keypad column reader.
// Helpers take a zero-extended MAX_COLS-wide vector so one function serves every N_COLS.
package keypad_pkg;

    localparam int unsigned MAX_COLS = 32;
    localparam int unsigned MAX_IDX_W = 5;

    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} rd_state_t;

    function automatic logic is_onehot(input logic [MAX_COLS-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_COLS-1:0] v);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MAX_COLS; i++) begin
            if (v[i]) idx = i[MAX_IDX_W-1:0];
        end
        return idx;
    endfunction

endpackage

// File: rtl/pin_sync.sv
// Multi-stage flip-flop synchroniser for a bus of asynchronous pins.
// Synchronous active-low reset loads every stage with RST_VAL.
module pin_sync #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < STAGES; i++) stage[i] <= RST_VAL;
        end else begin
            stage[0] <= d;
            for (int unsigned i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/keypad_col_reader.sv
// Debounced keypad column reader: synchronise, decode one-hot, debounce press and release.
// The release strobe port is named 'released' because 'release' is a reserved word.
module keypad_col_reader
    import keypad_pkg::*;
#(
    parameter int unsigned N_COLS          = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned ACTIVE_LOW      = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_COLS-1:0]         pin,
    output logic [N_COLS-1:0]         sense,
    output logic [$clog2(N_COLS)-1:0] col_idx,
    output logic                      held,
    output logic                      press,
    output logic                      released,
    output logic                      multi
);

    localparam int unsigned IDX_W = $clog2(N_COLS);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [N_COLS-1:0] INACTIVE = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [N_COLS-1:0]   sync_q;
    logic [N_COLS-1:0]   act;
    logic [MAX_COLS-1:0] act_ext;
    logic [N_COLS-1:0]   code;
    logic                act_onehot;
    logic [MAX_IDX_W-1:0] cand_idx;

    rd_state_t           state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [N_COLS-1:0]   cand, cand_nxt;
    logic [N_COLS-1:0]   sense_nxt;
    logic [IDX_W-1:0]    idx_nxt;
    logic                press_nxt, rel_nxt;

    pin_sync #(
        .WIDTH   (N_COLS),
        .STAGES  (SYNC_STAGES),
        .RST_VAL (INACTIVE)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pin),
        .q     (sync_q)
    );

    assign act        = sync_q ^ INACTIVE;
    assign act_ext    = MAX_COLS'(act);
    assign act_onehot = is_onehot(act_ext);
    assign code       = act_onehot ? act : '0;
    assign cand_idx   = onehot_to_idx(MAX_COLS'(cand));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cand_nxt  = cand;
        sense_nxt = sense;
        idx_nxt   = col_idx;
        press_nxt = 1'b0;
        rel_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (code != '0) begin
                    cand_nxt  = code;
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = PRESS_DB;
                end
            end
            PRESS_DB: begin
                if (code == cand) begin
                    if (cnt == CNT_LAST) begin
                        state_nxt = HELD;
                        cnt_nxt   = '0;
                        sense_nxt = cand;
                        idx_nxt   = cand_idx[IDX_W-1:0];
                        press_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end else begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            HELD: begin
                if (code != sense) begin
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = REL_DB;
                end
            end
            REL_DB: begin
                if (code == sense) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    sense_nxt = '0;
                    idx_nxt   = '0;
                    rel_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            cand     <= '0;
            sense    <= '0;
            col_idx  <= '0;
            held     <= 1'b0;
            press    <= 1'b0;
            released <= 1'b0;
            multi    <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            cand     <= cand_nxt;
            sense    <= sense_nxt;
            col_idx  <= idx_nxt;
            held     <= (state_nxt == HELD) || (state_nxt == REL_DB);
            press    <= press_nxt;
            released <= rel_nxt;
            multi    <= (act != '0) && !act_onehot;
        end
    end

endmodule

// File: tb/tb_keypad_col_reader.sv
// Directed bench: default 4-column active-low reader plus a 3-column active-high variant.
module tb_keypad_col_reader;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] pa;
    logic [3:0] a_sense;
    logic [1:0] a_idx;
    logic       a_held, a_press, a_rel, a_multi;
    logic [2:0] pb;
    logic [2:0] b_sense;
    logic [1:0] b_idx;
    logic       b_held, b_press, b_rel, b_multi;

    int errors = 0;
    int checks = 0;
    int cyc, press_cnt, press_at, rel_cnt, rel_at, multi_cnt, held_cnt, both_cnt;
    int b_press_cnt, b_press_at, b_rel_cnt, b_rel_at;

    always #5 clk = ~clk;

    keypad_col_reader dut_a (
        .clk(clk), .reset(reset), .pin(pa), .sense(a_sense), .col_idx(a_idx),
        .held(a_held), .press(a_press), .released(a_rel), .multi(a_multi)
    );

    keypad_col_reader #(
        .N_COLS(3), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(0)
    ) dut_b (
        .clk(clk), .reset(reset), .pin(pb), .sense(b_sense), .col_idx(b_idx),
        .held(b_held), .press(b_press), .released(b_rel), .multi(b_multi)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear();
        cyc = 0; press_cnt = 0; press_at = -1; rel_cnt = 0; rel_at = -1;
        multi_cnt = 0; held_cnt = 0;
        b_press_cnt = 0; b_press_at = -1; b_rel_cnt = 0; b_rel_at = -1;
    endtask

    // Edge k after the last clear() is observed with cyc == k.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (a_press) begin press_cnt++; press_at = cyc; end
            if (a_rel) begin rel_cnt++; rel_at = cyc; end
            if (a_multi) multi_cnt++;
            if (a_held) held_cnt++;
            if (a_press && a_rel) both_cnt++;
            if (b_press) begin b_press_cnt++; b_press_at = cyc; end
            if (b_rel) begin b_rel_cnt++; b_rel_at = cyc; end
            if (b_press && b_rel) both_cnt++;
        end
    endtask

    initial begin
        both_cnt = 0;
        reset = 1'b0; pa = 4'b1111; pb = 3'b000;
        clear();
        step(3);
        check("rst_sense", a_sense, 4'b0000);
        check("rst_idx", a_idx, 0);
        check("rst_flags", {a_held, a_press, a_rel, a_multi}, 4'b0000);
        check("rst_b_flags", {b_sense, b_held, b_press, b_rel, b_multi}, 0);
        reset = 1'b1;

        clear(); step(50);
        check("idle_press", press_cnt, 0);
        check("idle_rel", rel_cnt, 0);
        check("idle_multi", multi_cnt, 0);
        check("idle_held", held_cnt, 0);
        check("idle_sense", a_sense, 4'b0000);

        pa = 4'b1011; clear(); step(25);
        check("p2_cnt", press_cnt, 1);
        check("p2_at", press_at, 18);
        check("p2_sense", a_sense, 4'b0100);
        check("p2_idx", a_idx, 2);
        check("p2_held", a_held, 1);

        pa = 4'b1111; clear(); step(5);
        pa = 4'b1011; step(10);
        check("rbounce_rel", rel_cnt, 0);
        check("rbounce_sense", a_sense, 4'b0100);
        check("rbounce_held", a_held, 1);

        pa = 4'b1111; clear(); step(25);
        check("rel_cnt", rel_cnt, 1);
        check("rel_at", rel_at, 18);
        check("rel_sense", a_sense, 4'b0000);
        check("rel_idx", a_idx, 0);
        check("rel_held", a_held, 0);

        pa = 4'b1110; clear(); step(10);
        pa = 4'b1111; step(2);
        check("pbounce_early", press_cnt, 0);
        pa = 4'b1110; clear(); step(25);
        check("pbounce_cnt", press_cnt, 1);
        check("pbounce_at", press_at, 18);
        check("pbounce_idx", a_idx, 0);
        check("pbounce_sense", a_sense, 4'b0001);
        pa = 4'b1111; clear(); step(25);
        check("pbounce_rel", rel_cnt, 1);

        pa = 4'b0101; clear(); step(2);
        check("multi_e2", a_multi, 0);
        step(1);
        check("multi_e3", a_multi, 1);
        step(25);
        check("multi_nopress", press_cnt, 0);
        check("multi_noheld", held_cnt, 0);

        pa = 4'b0111; clear(); step(25);
        check("c3_press", press_cnt, 1);
        check("c3_sense", a_sense, 4'b1000);
        check("c3_idx", a_idx, 3);
        check("c3_multi", a_multi, 0);
        pa = 4'b0101; clear(); step(25);
        check("c3m_rel", rel_cnt, 1);
        check("c3m_rel_at", rel_at, 18);
        check("c3m_sense", a_sense, 4'b0000);
        check("c3m_multi", a_multi, 1);
        check("c3m_nopress", press_cnt, 0);
        pa = 4'b1111; step(10);

        // Reset lands while PRESS_DB holds cnt=9 (after edge 11).
        pa = 4'b1101; clear(); step(11);
        reset = 1'b0; step(1);
        check("rmid_out", {a_sense, a_idx, a_held, a_press, a_rel, a_multi}, 0);
        pa = 4'b1111; step(2);
        reset = 1'b1; step(25);
        check("rmid_nopress", press_cnt, 0);
        check("rmid_norel", rel_cnt, 0);

        pb = 3'b100; clear(); step(12);
        check("b_press_cnt", b_press_cnt, 1);
        check("b_press_at", b_press_at, 7);
        check("b_idx", b_idx, 2);
        check("b_sense", b_sense, 3'b100);
        pb = 3'b000; clear(); step(12);
        check("b_rel_cnt", b_rel_cnt, 1);
        check("b_rel_at", b_rel_at, 7);
        check("b_rel_sense", b_sense, 3'b000);

        check("strobe_overlap", both_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
